// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction-fetch stage.
//   FETCH_ADDR_WIDTH  default program-counter / memory-address width
//   FETCH_INSTR_WIDTH default instruction word width
//   FETCH_QUEUE_DEPTH default prefetch queue depth
//   FETCH_PC_STEP     default byte increment per sequential fetch
//   fetch_entry_t     one queued {pc, instr} pair at the default widths
package fetch_pkg;

    localparam int FETCH_ADDR_WIDTH  = 32;
    localparam int FETCH_INSTR_WIDTH = 32;
    localparam int FETCH_QUEUE_DEPTH = 4;
    localparam int FETCH_PC_STEP     = 4;

    typedef struct packed {
        logic [FETCH_ADDR_WIDTH-1:0]  pc;
        logic [FETCH_INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO holding fetched {pc, instr} entries.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   flush           clears all entries on the next edge (wins over push/pop)
//   push, wr_data   write one entry; accepted when not full or popping
//   pop             discard head entry; ignored when empty
//   rd_data         head entry, all-zero when empty
//   count           current occupancy
module fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             pop_ok_s;
    logic             push_ok_s;

    // Qualify requests: pop needs data, push needs room unless a pop frees a slot.
    always_comb begin
        pop_ok_s  = 1'b0;
        push_ok_s = 1'b0;
        if (flush) begin
            pop_ok_s  = 1'b0;
            push_ok_s = 1'b0;
        end else begin
            pop_ok_s  = pop && (count_r != '0);
            push_ok_s = push && ((count_r != FULL_COUNT) || pop_ok_s);
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are don't-care while not counted as occupied.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Head presentation, zeroed when nothing is queued.
    always_comb begin
        rd_data = '0;
        if (count_r != '0) begin
            rd_data = mem_r[rd_ptr_r];
        end else begin
            rd_data = '0;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage with prefetch queue, redirect and back-pressure.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned redirects fault and halt
// fetching instead of being silently aligned).
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   fetch_en                   permits new fetches into the queue
//   redirect_valid/redirect_pc taken branch and its target; flushes the queue
//   imem_addr / imem_data      instruction-memory address (the PC) and its comb. read data
//   if_id_valid/ready          handshake towards decode
//   if_id_pc / if_id_instr     head entry, zero when empty
//   queue_count                queue occupancy
//   fetch_fault                sticky misaligned-redirect flag
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH  = FETCH_ADDR_WIDTH,
    parameter int INSTR_WIDTH = FETCH_INSTR_WIDTH,
    parameter int QUEUE_DEPTH = FETCH_QUEUE_DEPTH,
    parameter int PC_STEP     = FETCH_PC_STEP,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             fetch_en,
    input  logic                             redirect_valid,
    input  logic [ADDR_WIDTH-1:0]            redirect_pc,
    output logic [ADDR_WIDTH-1:0]            imem_addr,
    input  logic [INSTR_WIDTH-1:0]           imem_data,
    output logic                             if_id_valid,
    input  logic                             if_id_ready,
    output logic [ADDR_WIDTH-1:0]            if_id_pc,
    output logic [INSTR_WIDTH-1:0]           if_id_instr,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_count,
    output logic                             fetch_fault
);

    localparam int ENTRY_W = ADDR_WIDTH + INSTR_WIDTH;
    localparam int CNT_W   = $clog2(QUEUE_DEPTH+1);
    localparam logic [CNT_W-1:0]      FULL_COUNT = CNT_W'(QUEUE_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(PC_STEP);
    // Low address bits that must be zero for an aligned fetch address.
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(PC_STEP - 1);

    logic [ADDR_WIDTH-1:0] pc_r;
    logic [ADDR_WIDTH-1:0] pc_next_s;
    logic [ENTRY_W-1:0]    head_s;
    logic [CNT_W-1:0]      count_s;
    logic                  halted_s;
    logic                  valid_s;
    logic                  push_s;
    logic                  pop_s;

`ifdef FETCH_ALIGN_CHECK_EN
    logic                  misaligned_s;
    logic                  halted_r;
    logic                  fault_r;

    assign misaligned_s = (redirect_pc & ALIGN_MASK) != '0;

    // Sticky fault/halt, only cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halted_r <= 1'b0;
            fault_r  <= 1'b0;
        end else if (redirect_valid && misaligned_s) begin
            halted_r <= 1'b1;
            fault_r  <= 1'b1;
        end else begin
            halted_r <= halted_r;
            fault_r  <= fault_r;
        end
    end

    assign halted_s    = halted_r;
    assign fetch_fault = fault_r;
`else
    assign halted_s    = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    assign valid_s = (count_s != '0);

    // Redirect suppresses both queue operations; a pop can make room for a push when full.
    always_comb begin
        pop_s  = 1'b0;
        push_s = 1'b0;
        if (redirect_valid) begin
            pop_s  = 1'b0;
            push_s = 1'b0;
        end else begin
            pop_s  = valid_s && if_id_ready;
            push_s = fetch_en && !halted_s && ((count_s < FULL_COUNT) || pop_s);
        end
    end

    // Next PC: redirect target (aligned, or held on a faulting redirect), else sequential step.
    always_comb begin
        pc_next_s = pc_r;
        if (redirect_valid) begin
`ifdef FETCH_ALIGN_CHECK_EN
            if (misaligned_s) begin
                pc_next_s = pc_r;
            end else begin
                pc_next_s = redirect_pc & ~ALIGN_MASK;
            end
`else
            pc_next_s = redirect_pc & ~ALIGN_MASK;
`endif
        end else if (push_s) begin
            pc_next_s = pc_r + STEP;
        end else begin
            pc_next_s = pc_r;
        end
    end

    // Program counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    fetch_queue #(
        .WIDTH (ENTRY_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .flush   (redirect_valid),
        .push    (push_s),
        .pop     (pop_s),
        .wr_data ({pc_r, imem_data}),
        .rd_data (head_s),
        .count   (count_s)
    );

    assign imem_addr   = pc_r;
    assign if_id_valid = valid_s;
    assign if_id_pc    = head_s[ENTRY_W-1 -: ADDR_WIDTH];
    assign if_id_instr = head_s[INSTR_WIDTH-1:0];
    assign queue_count = count_s;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit with a queue-based reference model.
// Honours FETCH_ALIGN_CHECK_EN the same way as the design.
module tb_fetch_unit;

`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_id_ready;
    logic        mem_mode;

    logic [31:0] imem_addr, imem_data, if_id_pc, if_id_instr;
    logic        if_id_valid, fetch_fault;
    logic [2:0]  queue_count;

    logic [31:0] imem_addr2, imem_data2, if_id_pc2, if_id_instr2;
    logic        if_id_valid2, fetch_fault2;
    logic [2:0]  queue_count2;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [63:0] m_q[$];
    bit          m_halt;
    bit          m_fault;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic mode);
        if (mode) return {a[7:0], a[31:8]} ^ 32'hC3A5_0F1E;
        else      return a;
    endfunction

    assign imem_data  = mem_word(imem_addr, mem_mode);
    assign imem_data2 = mem_word(imem_addr2, mem_mode);

    fetch_unit dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .if_id_valid(if_id_valid), .if_id_ready(if_id_ready),
        .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
        .queue_count(queue_count), .fetch_fault(fetch_fault)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .reset(reset), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr2), .imem_data(imem_data2),
        .if_id_valid(if_id_valid2), .if_id_ready(if_id_ready),
        .if_id_pc(if_id_pc2), .if_id_instr(if_id_instr2),
        .queue_count(queue_count2), .fetch_fault(fetch_fault2)
    );

    task automatic model_reset();
        m_q.delete();
        m_pc    = 32'h0;
        m_halt  = 1'b0;
        m_fault = 1'b0;
    endtask

    // Apply the fetch rules for the coming edge using the currently driven inputs.
    task automatic model_edge();
        bit          do_pop;
        bit          do_push;
        logic [63:0] dropped;
        if (reset) begin
            model_reset();
        end else if (redirect_valid) begin
            m_q.delete();
            if (ALIGN_CHK && (redirect_pc % 32'd4 != 32'd0)) begin
                m_halt  = 1'b1;
                m_fault = 1'b1;
            end else begin
                m_pc = redirect_pc - (redirect_pc % 32'd4);
            end
        end else begin
            do_pop  = (m_q.size() != 0) && if_id_ready;
            do_push = fetch_en && !m_halt && ((m_q.size() < 4) || do_pop);
            if (do_pop) dropped = m_q.pop_front();
            if (do_push) begin
                m_q.push_back({m_pc, mem_word(m_pc, mem_mode)});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] exp2;
        reset = 1'b1; fetch_en = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        if_id_ready = 1'b1; mem_mode = 1'b0;
        model_reset();
        repeat (2) tick();
        total_cnt++; if (if_id_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", if_id_valid); else pass_cnt++;
        total_cnt++; if (queue_count !== 3'd0) $display("FAIL reset_count: got %0d want 0", queue_count); else pass_cnt++;
        total_cnt++; if (if_id_pc !== 32'h0 || if_id_instr !== 32'h0) $display("FAIL reset_head: got %h/%h want 0/0", if_id_pc, if_id_instr); else pass_cnt++;
        total_cnt++; if (imem_addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", imem_addr); else pass_cnt++;
        total_cnt++; if (fetch_fault !== 1'b0) $display("FAIL reset_fault: got %b want 0", fetch_fault); else pass_cnt++;
        total_cnt++; if (imem_addr2 !== 32'hFFFF_FFF8) $display("FAIL reset_addr2: got %h want fffffff8", imem_addr2); else pass_cnt++;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'(i * 4) || if_id_instr !== 32'(i * 4))
                $display("FAIL startup_head%0d: got v=%b pc=%h in=%h want v=1 pc=%h", i, if_id_valid, if_id_pc, if_id_instr, 32'(i * 4));
            else pass_cnt++;
            exp2 = 32'hFFFF_FFF8 + 32'(i * 4);
            total_cnt++; if (if_id_valid2 !== 1'b1 || if_id_pc2 !== exp2 || if_id_instr2 !== exp2)
                $display("FAIL wrap_head%0d: got v=%b pc=%h in=%h want pc=%h", i, if_id_valid2, if_id_pc2, if_id_instr2, exp2);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        int exp_n;
        do_reset();
        if_id_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            exp_n = (i < 4) ? i : 4;
            total_cnt++; if (queue_count !== 3'(exp_n) || imem_addr !== 32'(exp_n * 4))
                $display("FAIL bp_fill%0d: got cnt=%0d addr=%h want cnt=%0d addr=%h", i, queue_count, imem_addr, exp_n, 32'(exp_n * 4));
            else pass_cnt++;
        end
        if_id_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            total_cnt++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'(i * 4))
                $display("FAIL bp_drain%0d: got v=%b pc=%h want pc=%h", i, if_id_valid, if_id_pc, 32'(i * 4));
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_redirect_full();
        if_id_ready = 1'b0;
        repeat (4) tick();
        total_cnt++; if (queue_count !== 3'd4) $display("FAIL redir_full: got cnt=%0d want 4", queue_count); else pass_cnt++;
        if_id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        total_cnt++; if (if_id_valid !== 1'b0 || queue_count !== 3'd0 || imem_addr !== 32'h100)
            $display("FAIL redir_flush: got v=%b cnt=%0d addr=%h want 0/0/100", if_id_valid, queue_count, imem_addr);
        else pass_cnt++;
        tick();
        total_cnt++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h100 || if_id_instr !== 32'h100 || imem_addr !== 32'h104)
            $display("FAIL redir_target: got v=%b pc=%h in=%h addr=%h want 1/100/100/104", if_id_valid, if_id_pc, if_id_instr, imem_addr);
        else pass_cnt++;
    endtask

    task automatic test_misaligned();
        logic [31:0] pc_before;
        pc_before = m_pc;
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        tick();
        redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        total_cnt++; if (fetch_fault !== 1'b1 || queue_count !== 3'd0 || imem_addr !== pc_before)
            $display("FAIL mis_fault: got f=%b cnt=%0d addr=%h want 1/0/%h", fetch_fault, queue_count, imem_addr, pc_before);
        else pass_cnt++;
        repeat (3) tick();
        total_cnt++; if (fetch_fault !== 1'b1 || if_id_valid !== 1'b0 || imem_addr !== pc_before)
            $display("FAIL mis_halt: got f=%b v=%b addr=%h want 1/0/%h", fetch_fault, if_id_valid, imem_addr, pc_before);
        else pass_cnt++;
        do_reset();
        total_cnt++; if (fetch_fault !== 1'b0) $display("FAIL mis_clear: got %b want 0", fetch_fault); else pass_cnt++;
`else
        total_cnt++; if (fetch_fault !== 1'b0 || queue_count !== 3'd0 || imem_addr !== 32'h100)
            $display("FAIL mis_align: got f=%b cnt=%0d addr=%h want 0/0/100 (from %h)", fetch_fault, queue_count, imem_addr, pc_before);
        else pass_cnt++;
        tick();
        total_cnt++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h100)
            $display("FAIL mis_head: got v=%b pc=%h want 1/100", if_id_valid, if_id_pc);
        else pass_cnt++;
`endif
    endtask

    task automatic test_async_reset();
        do_reset();
        if_id_ready = 1'b0;
        repeat (3) tick();
        total_cnt++; if (queue_count !== 3'd3) $display("FAIL ar_fill: got cnt=%0d want 3", queue_count); else pass_cnt++;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        total_cnt++; if (if_id_valid !== 1'b0 || queue_count !== 3'd0 || imem_addr !== 32'h0 || imem_addr2 !== 32'hFFFF_FFF8)
            $display("FAIL ar_clear: got v=%b cnt=%0d addr=%h addr2=%h want 0/0/0/fffffff8", if_id_valid, queue_count, imem_addr, imem_addr2);
        else pass_cnt++;
        tick();
        reset = 1'b0;
        if_id_ready = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] e_pc, e_in;
        mem_mode = 1'b1;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            reset          = ($urandom_range(0, 99) < 2);
            fetch_en       = ($urandom_range(0, 9) < 8);
            if_id_ready    = ($urandom_range(0, 9) < 6);
            redirect_valid = ($urandom_range(0, 99) < 8);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC);
            if ($urandom_range(0, 7) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
            tick();
            e_pc = (m_q.size() != 0) ? m_q[0][63:32] : 32'h0;
            e_in = (m_q.size() != 0) ? m_q[0][31:0] : 32'h0;
            total_cnt++; if (if_id_valid !== (m_q.size() != 0) || queue_count !== 3'(m_q.size()))
                $display("FAIL rnd_occ%0d: got v=%b cnt=%0d want cnt=%0d", i, if_id_valid, queue_count, m_q.size());
            else pass_cnt++;
            total_cnt++; if (if_id_pc !== e_pc || if_id_instr !== e_in)
                $display("FAIL rnd_head%0d: got %h/%h want %h/%h", i, if_id_pc, if_id_instr, e_pc, e_in);
            else pass_cnt++;
            total_cnt++; if (imem_addr !== m_pc || fetch_fault !== m_fault)
                $display("FAIL rnd_pc%0d: got addr=%h f=%b want %h/%b", i, imem_addr, fetch_fault, m_pc, m_fault);
            else pass_cnt++;
        end
        reset = 1'b0; redirect_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_redirect_full();
        test_misaligned();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage with a small prefetch queue, branch redirect and downstream back-pressure. It drives the instruction-memory address from its program counter and captures the combinational read data into a FIFO. It presents the oldest {pc, instruction} pair to the IF/ID boundary with a valid/ready handshake. It sits between instruction memory and the decode stage and replaces the fixed-width, stall-only fetch stage.

## Interface
- ADDR_WIDTH, 32, program-counter and memory-address width
- INSTR_WIDTH, 32, instruction word width
- QUEUE_DEPTH, 4, prefetch entries; power of two, >= 2
- PC_STEP, 4, byte increment per sequential fetch; power of two
- RESET_PC, 0, program-counter value after reset
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- fetch_en  in  1  permits new fetches into the queue
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  ADDR_WIDTH  target address for redirect
- imem_addr  out  ADDR_WIDTH  instruction-memory address, equals the current PC register
- imem_data  in  INSTR_WIDTH  combinational read data for imem_addr
- if_id_valid  out  1  queue head holds a valid instruction
- if_id_ready  in  1  decode accepts the head this cycle
- if_id_pc  out  ADDR_WIDTH  PC of the head entry
- if_id_instr  out  INSTR_WIDTH  instruction of the head entry
- queue_count  out  $clog2(QUEUE_DEPTH+1)  current occupancy
- fetch_fault  out  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- Push condition: fetch_en && !redirect_valid && !halted && (count < QUEUE_DEPTH || pop). The push writes {pc, imem_data}, and pc advances to pc + PC_STEP.
- Pop condition: if_id_valid && if_id_ready && !redirect_valid.
- Simultaneous push and pop is legal at any occupancy, including full. In that case count is unchanged.
- Redirect has highest priority. On an edge with redirect_valid high, the queue is cleared and count becomes 0. pc loads redirect_pc, and there is no push or pop that cycle.
- PC arithmetic is modulo 2^ADDR_WIDTH. Wrap from the top address to 0 is silent.
- Head outputs come from the FIFO read pointer. When the queue is empty, if_id_pc and if_id_instr are driven to 0.
- With fetch_en low, the queue drains normally and pc holds.

## Timing
- Reset values: pc = RESET_PC, so imem_addr = RESET_PC. Also if_id_valid = 0, if_id_pc = 0, if_id_instr = 0, queue_count = 0, fetch_fault = 0, halted = 0.
- Reset asserted mid-operation discards all entries immediately and asynchronously.
- Fetch latency: an instruction pushed at edge N is valid at the head after edge N if the queue was empty. First valid output appears one cycle after reset release with fetch_en high.
- Redirect latency: redirect at edge N leaves the queue empty after N. The target instruction is at the head after edge N+1.
- Steady state with ready held high delivers one instruction per cycle, with no bubbles.
- Once full with ready low, no further pushes occur and pc holds until a pop.

## Configuration
- FETCH_ALIGN_CHECK_EN defined: a redirect_pc with any of the low $clog2(PC_STEP) bits set still flushes the queue. However, it sets fetch_fault and halted, and pc is not updated. halted blocks all pushes until reset. fetch_fault stays high until reset.
- Macro undefined: the low $clog2(PC_STEP) bits of redirect_pc are forced to zero on load. fetch_fault is tied to 0 and halted never sets.

## Structure
- Shared package fetch_pkg holds the default parameter constants (FETCH_ADDR_WIDTH, FETCH_INSTR_WIDTH, FETCH_QUEUE_DEPTH, FETCH_PC_STEP). It also holds a fetch_entry_t struct {pc, instr}.
- One sub-module: fetch_queue. This is a synchronous FIFO with width ADDR_WIDTH+INSTR_WIDTH, depth QUEUE_DEPTH, a flush input, and a count output.
- The top level holds the PC register, the push/pop/redirect priority logic and the alignment check.

## Test plan
- Reset with fetch_en = 1, ready = 1, memory word = address: heads 0x00, 0x04, 0x08 appear on consecutive cycles after release, with no bubbles.
- Hold ready = 0 for 10 cycles (default params): queue_count goes 1, 2, 3, 4 then stays at 4, and imem_addr holds at 0x10. After ready is raised, heads 0x00 to 0x0C drain, then fetch continues.
- Redirect to 0x100 while the queue is full and ready = 1: the next cycle has if_id_valid = 0 and count = 0. The cycle after has if_id_pc = 0x100.
- Start with RESET_PC = 0xFFFFFFF8: fetched PCs are 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Redirect to 0x102: with FETCH_ALIGN_CHECK_EN, fetch_fault rises, the queue stays empty and pc holds. Without the macro, the head becomes 0x100.
- Assert reset asynchronously mid-cycle with 3 entries queued: if_id_valid and queue_count drop to 0 and imem_addr becomes RESET_PC before the next edge.
